// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int          PC_STEP         = 4;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int          DEFAULT_LAST_PC = 60;

endpackage : cpu_pkg

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-pc selection: redirect, increment or hold.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int LAST_PC = DEFAULT_LAST_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            at_last
);

  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] target_aligned;

  // Masking rather than slicing keeps the redirect word-aligned for any PC_W.
  assign target_aligned = target & ~PC_W'(3);

  // Addresses past the last legal word also halt, so a wild redirect cannot run off the end.
  assign at_last = (pc >= PC_W'(LAST_PC));

  // NOTE: every path assigns pc_next up front, so this block cannot infer a latch.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target_aligned;
    end else if (load && !at_last) begin
      pc_next = pc + PC_W'(PC_STEP);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule : fetch_pc_reg

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage with run/halt control and a saturating fetch counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int LAST_PC = DEFAULT_LAST_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic [PC_W-1:0] branch_target,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            halted,
  output logic [7:0]      fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            pc_at_last;
  logic            load;

  // A held instruction blocks a new fetch unless decode takes it this same cycle.
  assign load = (state == RUN) && !stall && !branch_valid && (!if_valid || if_ready);

  fetch_pc_reg #(
    .PC_W    (PC_W),
    .LAST_PC (LAST_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .redirect (branch_valid),
    .target   (branch_target),
    .pc       (pc),
    .at_last  (pc_at_last)
  );

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      fetch_count <= '0;
    end else if (branch_valid) begin
      // Redirect squashes the held instruction and revives a halted fetch.
      state    <= RUN;
      if_valid <= 1'b0;
    end else if (load) begin
      if_instr <= imem_instr;
      if_pc    <= pc;
      if_valid <= 1'b1;
      if (fetch_count != 8'hFF) begin
        fetch_count <= fetch_count + 8'd1;
      end
      if (pc_at_last) begin
        state <= HALT;
      end
    end else if (if_valid && if_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule : fetch_unit
